// File: rtl/dual_fetch_boot_mem.sv
// Unified instruction/data RAM with FETCH_WIDTH fetch lanes, one load/store port and a CLEAR -> LOAD -> RUN boot loader.
// Optional MEM_INIT_FILE_EN: start in LOAD instead of CLEAR so existing array contents survive reset.
module dual_fetch_boot_mem #(
    parameter int DEPTH       = 4096,
    parameter int FETCH_WIDTH = 2
`ifdef MEM_INIT_FILE_EN
    , parameter string INIT_FILE = "boot.hex"
`endif
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      io_reset,
    input  logic [63:0]               io_if_mem_instAddr,
    input  logic [63:0]               io_ex_mem_dataAddr,
    input  logic                      io_ex_mem_writeEn,
    input  logic [31:0]               io_ex_mem_writeData,
    input  logic [2:0]                io_ex_mem_func3,
    input  logic                      io_load_valid,
    input  logic [31:0]               io_load_data,
    input  logic                      io_load_done,
    output logic                      io_load_ready,
    output logic                      io_ready,
    output logic [32*FETCH_WIDTH-1:0] io_mem_id_inst,
    output logic [31:0]               io_mem_lsu_data,
    output logic                      io_misaligned
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST_WORD = AW'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_LOAD,
        ST_RUN
    } state_t;

`ifdef MEM_INIT_FILE_EN
    localparam state_t RESET_STATE = ST_LOAD;
`else
    localparam state_t RESET_STATE = ST_CLEAR;
`endif

    state_t        state, state_next;
    logic [AW-1:0] ptr, ptr_next;
    logic [31:0]   mem [DEPTH];

    logic [AW-1:0] fetch_base;
    logic [AW-1:0] data_idx;
    logic [1:0]    data_off;
    logic          is_byte, is_half, is_word, misaligned, run;
    logic [3:0]    wr_be;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;
    logic [31:0]   rd_word, load_value;
    logic [7:0]    sel_byte;
    logic [15:0]   sel_half;
    logic          unused_addr_bits;

    assign fetch_base = io_if_mem_instAddr[AW+1:2];
    assign data_idx   = io_ex_mem_dataAddr[AW+1:2];
    assign data_off   = io_ex_mem_dataAddr[1:0];
    assign is_byte    = (io_ex_mem_func3[1:0] == 2'b00);
    assign is_half    = (io_ex_mem_func3[1:0] == 2'b01);
    assign is_word    = !is_byte && !is_half;
    assign misaligned = (is_half && data_off[0]) || (is_word && (data_off != 2'b00));
    assign run        = (state == ST_RUN);
    assign io_ready      = run;
    assign io_load_ready = (state == ST_LOAD);

    // Upper address bits alias onto the array; the byte offset of a fetch address is meaningless.
    assign unused_addr_bits = ^{io_if_mem_instAddr[63:AW+2], io_if_mem_instAddr[1:0],
                                io_ex_mem_dataAddr[63:AW+2]};

    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        if (io_reset) begin
            state_next = ST_LOAD;
            ptr_next   = '0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    ptr_next = ptr + 1'b1;
                    if (ptr == LAST_WORD) state_next = ST_LOAD;
                end
                ST_LOAD: begin
                    if (io_load_valid) begin
                        ptr_next = ptr + 1'b1;
                        if (ptr == LAST_WORD) state_next = ST_RUN;
                    end
                    if (io_load_done) state_next = ST_RUN;
                end
                default: ;
            endcase
        end
    end

    // Clear, boot and store traffic share the one write port; they are mutually exclusive by state.
    always_comb begin
        wr_be   = 4'b0000;
        wr_addr = ptr;
        wr_data = 32'h0;
        if (!reset && !io_reset) begin
            case (state)
                ST_CLEAR: wr_be = 4'b1111;
                ST_LOAD: begin
                    if (io_load_valid) begin
                        wr_be   = 4'b1111;
                        wr_data = io_load_data;
                    end
                end
                ST_RUN: begin
                    if (io_ex_mem_writeEn && !misaligned) begin
                        wr_addr = data_idx;
                        case (io_ex_mem_func3)
                            3'b000: begin
                                wr_be   = 4'b0001 << data_off;
                                wr_data = {4{io_ex_mem_writeData[7:0]}};
                            end
                            3'b001: begin
                                wr_be   = data_off[1] ? 4'b1100 : 4'b0011;
                                wr_data = {2{io_ex_mem_writeData[15:0]}};
                            end
                            3'b010: begin
                                wr_be   = 4'b1111;
                                wr_data = io_ex_mem_writeData;
                            end
                            default: ;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        for (int b = 0; b < 4; b++) begin
            if (wr_be[b]) mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
        end
    end

    assign rd_word  = mem[data_idx];
    assign sel_byte = rd_word[8*data_off +: 8];
    assign sel_half = data_off[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        case (io_ex_mem_func3)
            3'b000:  load_value = {{24{sel_byte[7]}}, sel_byte};
            3'b001:  load_value = {{16{sel_half[15]}}, sel_half};
            3'b100:  load_value = {24'h0, sel_byte};
            3'b101:  load_value = {16'h0, sel_half};
            default: load_value = rd_word;
        endcase
    end

    // Reads sample the array before this edge's write lands, so a colliding read sees old data.
    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= RESET_STATE;
            ptr             <= '0;
            io_mem_id_inst  <= '0;
            io_mem_lsu_data <= 32'h0;
            io_misaligned   <= 1'b0;
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
            for (int i = 0; i < FETCH_WIDTH; i++) begin
                io_mem_id_inst[32*i +: 32] <= run ? mem[fetch_base + AW'(i)] : 32'h0;
            end
            io_mem_lsu_data <= (run && !misaligned) ? load_value : 32'h0;
            io_misaligned   <= run && misaligned;
        end
    end

endmodule

// File: tb/tb_dual_fetch_boot_mem.sv
// Self-checking bench for dual_fetch_boot_mem: a per-cycle behavioural model plus directed literal checks.
module tb_dual_fetch_boot_mem;

    localparam int DEPTH = 4096;
    localparam int FW    = 2;

    logic          clock = 1'b0;
    logic          reset, io_reset;
    logic [63:0]   io_if_mem_instAddr, io_ex_mem_dataAddr;
    logic          io_ex_mem_writeEn;
    logic [31:0]   io_ex_mem_writeData;
    logic [2:0]    io_ex_mem_func3;
    logic          io_load_valid, io_load_done;
    logic [31:0]   io_load_data;
    logic          io_load_ready, io_ready, io_misaligned;
    logic [32*FW-1:0] io_mem_id_inst;
    logic [31:0]   io_mem_lsu_data;

    int num_compared   = 0;
    int num_mismatched = 0;

    dual_fetch_boot_mem #(.DEPTH(DEPTH), .FETCH_WIDTH(FW)) dut (
        .clock(clock),
        .reset(reset),
        .io_reset(io_reset),
        .io_if_mem_instAddr(io_if_mem_instAddr),
        .io_ex_mem_dataAddr(io_ex_mem_dataAddr),
        .io_ex_mem_writeEn(io_ex_mem_writeEn),
        .io_ex_mem_writeData(io_ex_mem_writeData),
        .io_ex_mem_func3(io_ex_mem_func3),
        .io_load_valid(io_load_valid),
        .io_load_data(io_load_data),
        .io_load_done(io_load_done),
        .io_load_ready(io_load_ready),
        .io_ready(io_ready),
        .io_mem_id_inst(io_mem_id_inst),
        .io_mem_lsu_data(io_mem_lsu_data),
        .io_misaligned(io_misaligned)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        num_compared++;
        if (actual !== expected) begin
            num_mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // phase: 0 = clearing, 1 = accepting boot words, 2 = running
    int          m_phase, m_ptr;
    logic [31:0] m_mem [DEPTH];
    logic [32*FW-1:0] e_inst;
    logic [31:0] e_lsu;
    logic        e_mis, e_ready, e_lready;
    bit          m_valid = 0;
    int          m_widx, m_off, m_size, m_fidx;
    bit          m_mis, m_full;

    function automatic logic [31:0] extract(logic [31:0] w, int off, int size, bit sgn);
        longint v;
        v = longint'(w >> (8 * off));
        if (size == 1) begin
            v = v % 256;
            if (sgn && v >= 128) v -= 256;
        end else if (size == 2) begin
            v = v % 65536;
            if (sgn && v >= 32768) v -= 65536;
        end
        return v[31:0];
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            m_phase = 0; m_ptr = 0;
            e_inst = '0; e_lsu = 0; e_mis = 0;
            m_valid = 1;
        end else begin
            m_widx = int'((io_ex_mem_dataAddr >> 2) % 64'(DEPTH));
            m_off  = int'(io_ex_mem_dataAddr % 64'd4);
            case (io_ex_mem_func3)
                3'd0, 3'd4: m_size = 1;
                3'd1, 3'd5: m_size = 2;
                default:    m_size = 4;
            endcase
            m_mis = (m_off % m_size) != 0;
            if (m_phase == 2) begin
                for (int l = 0; l < FW; l++) begin
                    m_fidx = int'(((io_if_mem_instAddr >> 2) + 64'(l)) % 64'(DEPTH));
                    e_inst[32*l +: 32] = m_mem[m_fidx];
                end
                e_lsu = m_mis ? 32'h0 : extract(m_mem[m_widx], m_off, m_size, !io_ex_mem_func3[2]);
                e_mis = m_mis;
            end else begin
                e_inst = '0; e_lsu = 0; e_mis = 0;
            end
            if (io_reset) begin
                m_phase = 1; m_ptr = 0;
            end else if (m_phase == 0) begin
                m_mem[m_ptr] = 32'h0;
                if (m_ptr == DEPTH - 1) begin m_ptr = 0; m_phase = 1; end
                else m_ptr++;
            end else if (m_phase == 1) begin
                m_full = 0;
                if (io_load_valid) begin
                    m_mem[m_ptr] = io_load_data;
                    if (m_ptr == DEPTH - 1) begin m_ptr = 0; m_full = 1; end
                    else m_ptr++;
                end
                if (m_full || io_load_done) m_phase = 2;
            end else if (io_ex_mem_writeEn && !m_mis && io_ex_mem_func3 <= 3'd2) begin
                for (int b = 0; b < m_size; b++)
                    m_mem[m_widx][8*(m_off+b) +: 8] = io_ex_mem_writeData[8*b +: 8];
            end
        end
        e_ready  = (m_phase == 2);
        e_lready = (m_phase == 1);
    end

    always @(negedge clock) begin
        if (m_valid) begin
            checkOutput("model_inst", 64'(io_mem_id_inst), 64'(e_inst));
            checkOutput("model_lsu", 64'(io_mem_lsu_data), 64'(e_lsu));
            checkOutput("model_misaligned", 64'(io_misaligned), 64'(e_mis));
            checkOutput("model_ready", 64'(io_ready), 64'(e_ready));
            checkOutput("model_load_ready", 64'(io_load_ready), 64'(e_lready));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [63:0] daddr,
                                 input logic [31:0] wd);
        io_ex_mem_writeEn   = we;
        io_ex_mem_func3     = f3;
        io_ex_mem_dataAddr  = daddr;
        io_ex_mem_writeData = wd;
        step();
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1; io_reset = 0;
        io_if_mem_instAddr = 64'h40; io_ex_mem_dataAddr = 0;
        io_ex_mem_writeEn = 0; io_ex_mem_writeData = 0; io_ex_mem_func3 = 3'd2;
        io_load_valid = 0; io_load_data = 0; io_load_done = 0;
        repeat (3) step();
        checkOutput("reset_inst", 64'(io_mem_id_inst), 64'h0);
        checkOutput("reset_ready", 64'(io_ready), 64'h0);
        reset = 0;

        for (int c = 1; c < DEPTH; c++) step();
        checkOutput("clear_not_done", 64'(io_load_ready), 64'h0);
        step();
        checkOutput("clear_done_load_ready", 64'(io_load_ready), 64'h1);
        checkOutput("clear_done_ready", 64'(io_ready), 64'h0);

        io_load_valid = 1; io_load_data = 32'h0000_0013; step();
        io_load_data = 32'h0010_0093; step();
        io_load_data = 32'h0020_0113; io_load_done = 1; step();
        checkOutput("boot_ready", 64'(io_ready), 64'h1);
        io_load_valid = 0; io_load_done = 0;

        io_if_mem_instAddr = 64'h0;
        applyStimulus(0, 3'd2, 64'h0, 0);
        checkOutput("fetch_addr0", 64'(io_mem_id_inst), 64'h0010_0093_0000_0013);
        io_if_mem_instAddr = 64'h4;
        applyStimulus(0, 3'd2, 64'h0, 0);
        checkOutput("fetch_addr4", 64'(io_mem_id_inst), 64'h0020_0113_0010_0093);
        io_if_mem_instAddr = 64'((DEPTH - 1) * 4);
        applyStimulus(0, 3'd2, 64'h0, 0);
        checkOutput("fetch_wrap", 64'(io_mem_id_inst), 64'h0000_0013_0000_0000);

        applyStimulus(1, 3'd2, 64'h100, 32'h80FF_7F01);
        applyStimulus(0, 3'd0, 64'h100, 0);
        checkOutput("lb_100", 64'(io_mem_lsu_data), 64'h0000_0001);
        applyStimulus(0, 3'd0, 64'h101, 0);
        checkOutput("lb_101", 64'(io_mem_lsu_data), 64'h0000_007F);
        applyStimulus(0, 3'd0, 64'h102, 0);
        checkOutput("lb_102", 64'(io_mem_lsu_data), 64'hFFFF_FFFF);
        applyStimulus(0, 3'd4, 64'h102, 0);
        checkOutput("lbu_102", 64'(io_mem_lsu_data), 64'h0000_00FF);
        applyStimulus(0, 3'd1, 64'h102, 0);
        checkOutput("lh_102", 64'(io_mem_lsu_data), 64'hFFFF_80FF);

        applyStimulus(1, 3'd1, 64'h101, 32'h0000_BEEF);
        checkOutput("sh_misaligned_flag", 64'(io_misaligned), 64'h1);
        applyStimulus(0, 3'd2, 64'h100, 0);
        checkOutput("sh_misaligned_unchanged", 64'(io_mem_lsu_data), 64'h80FF_7F01);
        applyStimulus(0, 3'd2, 64'h102, 0);
        checkOutput("lw_misaligned_data", 64'(io_mem_lsu_data), 64'h0);
        checkOutput("lw_misaligned_flag", 64'(io_misaligned), 64'h1);

        applyStimulus(1, 3'd2, 64'h200, 32'h1122_3344);
        io_if_mem_instAddr = 64'h200;
        applyStimulus(1, 3'd2, 64'h200, 32'hA5A5_A5A5);
        checkOutput("collide_load_old", 64'(io_mem_lsu_data), 64'h1122_3344);
        checkOutput("collide_fetch_old", 64'(io_mem_id_inst[31:0]), 64'h1122_3344);
        applyStimulus(0, 3'd2, 64'h200, 0);
        checkOutput("collide_load_new", 64'(io_mem_lsu_data), 64'hA5A5_A5A5);
        applyStimulus(1, 3'd0, 64'h203, 32'h0000_005A);
        applyStimulus(0, 3'd5, 64'h202, 0);
        checkOutput("sb_lhu", 64'(io_mem_lsu_data), 64'h0000_5AA5);
        applyStimulus(1, 3'd3, 64'h200, 32'h0);
        applyStimulus(0, 3'd2, 64'h200 | (64'h1 << 40), 0);
        checkOutput("bad_store_alias_lw", 64'(io_mem_lsu_data), 64'h5AA5_A5A5);

        io_reset = 1; io_if_mem_instAddr = 64'h0;
        applyStimulus(0, 3'd2, 64'h0, 0);
        checkOutput("soft_reset_ready", 64'(io_ready), 64'h0);
        checkOutput("soft_reset_load_ready", 64'(io_load_ready), 64'h1);
        io_reset = 0;
        step();
        checkOutput("soft_reset_fetch_idle", 64'(io_mem_id_inst), 64'h0);
        io_load_done = 1; step();
        io_load_done = 0; step();
        checkOutput("soft_reset_kept", 64'(io_mem_id_inst), 64'h0010_0093_0000_0013);

        io_reset = 1; step();
        io_reset = 0;
        io_load_valid = 1;
        for (int i = 0; i < DEPTH; i++) begin
            io_load_data = 32'h1000_0000 + 32'(i);
            step();
        end
        io_load_valid = 0;
        checkOutput("full_load_ready", 64'(io_ready), 64'h1);
        io_if_mem_instAddr = 64'((DEPTH - 1) * 4);
        step();
        checkOutput("full_load_fetch", 64'(io_mem_id_inst), 64'h1000_0000_1000_0FFF);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
        $finish;
    end

endmodule
